rf_ifm_feeder: RTL

- Producer end of the ifm row-register interface.
- Reads a programmed sequence of COL*8-bit ifm rows from the ifm SRAM bank and drives ifm_out/ifm_read into the per-PE-row ifm register file.
- Sits between the ifm SRAM and the RU array's input register files; started by the layer controller, which receives a one-cycle done pulse.

---
 rtl/rf_ifm_feeder_if.sv | 62 ++++++
 rtl/rf_ifm_feeder.sv | 128 ++++++++++++
 2 files changed

// File: rtl/rf_ifm_feeder_if.sv
// Bundle between the ifm feeder, the ifm SRAM bank, the layer controller
// and the PE-row register file. IFM_FEED_ZPAD_EN adds pad_top/pad_bot.
interface rf_ifm_feeder_if #(
    parameter int COL    = 8,
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 8
);
    logic                start;
    logic [ADDR_W-1:0]   base_addr;
    logic [CNT_W-1:0]    num_rows;
    logic [CNT_W-1:0]    row_stride;
`ifdef IFM_FEED_ZPAD_EN
    logic [CNT_W-1:0]    pad_top;
    logic [CNT_W-1:0]    pad_bot;
`endif
    logic                stall;
    logic                sram_ren;
    logic [ADDR_W-1:0]   sram_addr;
    logic [COL*8-1:0]    sram_rdata;
    logic [COL*8-1:0]    ifm_out;
    logic                ifm_read;
    logic                busy;
    logic                done;

    modport master (
`ifdef IFM_FEED_ZPAD_EN
        input  pad_top,
        input  pad_bot,
`endif
        input  start,
        input  base_addr,
        input  num_rows,
        input  row_stride,
        input  stall,
        input  sram_rdata,
        output sram_ren,
        output sram_addr,
        output ifm_out,
        output ifm_read,
        output busy,
        output done
    );

    modport slave (
`ifdef IFM_FEED_ZPAD_EN
        output pad_top,
        output pad_bot,
`endif
        output start,
        output base_addr,
        output num_rows,
        output row_stride,
        output stall,
        output sram_rdata,
        input  sram_ren,
        input  sram_addr,
        input  ifm_out,
        input  ifm_read,
        input  busy,
        input  done
    );
endinterface

// File: rtl/rf_ifm_feeder.sv
// Streams programmed ifm rows from SRAM into the PE-row register file.
// IFM_FEED_ZPAD_EN adds zero pad rows before/after the SRAM rows.
module rf_ifm_feeder #(
    parameter int COL    = 8,
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    rf_ifm_feeder_if.master   bus
);
    localparam int CW = CNT_W + 2;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        state;
    logic [ADDR_W-1:0] addr;
    logic [CNT_W-1:0]  stride;
    logic [CW-1:0]     total;
    logic [CW-1:0]     issued;
    logic [CW-1:0]     delivered;
    logic              pend;
    logic              pend_pad;
    logic              skid_v;
    logic [COL*8-1:0]  skid;
    logic [COL*8-1:0]  out_q;
    logic              read_q;
    logic              accept;
    logic              iss;
    logic              is_pad;
    logic [CW-1:0]     start_total;

    // Every delivered row (SRAM or pad) is one "slot" in a single sequence.
`ifdef IFM_FEED_ZPAD_EN
    logic [CNT_W-1:0]  ptop;
    logic [CNT_W-1:0]  nrows;
    assign start_total = CW'(bus.pad_top) + CW'(bus.num_rows)
                       + CW'(bus.pad_bot);
    assign is_pad = (issued < CW'(ptop)) ||
                    (issued >= CW'(ptop) + CW'(nrows));
`else
    assign start_total = CW'(bus.num_rows);
    assign is_pad = 1'b0;
`endif

    assign accept = (state == S_IDLE) && bus.start;
    assign iss = (state == S_RUN) && (issued < total) &&
                 !bus.stall && !skid_v;

    assign bus.sram_ren  = iss && !is_pad;
    assign bus.sram_addr = addr;
    assign bus.ifm_out   = out_q;
    assign bus.ifm_read  = read_q;
    assign bus.done      = (state == S_DONE);
    assign bus.busy      = (state != S_IDLE) || accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            addr      <= '0;
            stride    <= '0;
            total     <= '0;
            issued    <= '0;
            delivered <= '0;
            pend      <= 1'b0;
            pend_pad  <= 1'b0;
            skid_v    <= 1'b0;
            skid      <= '0;
            out_q     <= '0;
            read_q    <= 1'b0;
`ifdef IFM_FEED_ZPAD_EN
            ptop      <= '0;
            nrows     <= '0;
`endif
        end else begin
            pend     <= iss;
            pend_pad <= iss && is_pad;
            read_q   <= 1'b0;
            // A returning row never coincides with a full skid: issue
            // needs both stall low and the skid empty.
            if (pend && !bus.stall) begin
                out_q  <= pend_pad ? '0 : bus.sram_rdata;
                read_q <= 1'b1;
            end else if (pend) begin
                skid   <= pend_pad ? '0 : bus.sram_rdata;
                skid_v <= 1'b1;
            end else if (skid_v && !bus.stall) begin
                out_q  <= skid;
                read_q <= 1'b1;
                skid_v <= 1'b0;
            end
            if (read_q)
                delivered <= delivered + 1'b1;
            if (iss)
                issued <= issued + 1'b1;
            if (bus.sram_ren)
                addr <= addr + ADDR_W'(stride);

            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        addr      <= bus.base_addr;
                        stride    <= bus.row_stride;
                        total     <= start_total;
                        issued    <= '0;
                        delivered <= '0;
`ifdef IFM_FEED_ZPAD_EN
                        ptop      <= bus.pad_top;
                        nrows     <= bus.num_rows;
`endif
                        state <= (start_total == '0) ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    if (iss && (issued + 1'b1 == total))
                        state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (read_q && (delivered + 1'b1 == total))
                        state <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
